// File: rtl/bridge_pkg.sv
// Shared types and the byte-strobe helper for the parametrised AHB-to-APB bridge.
package bridge_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WWAIT  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } bridge_state_e;

    // Byte lanes for a transfer of 2**hsize bytes on a bus of 2**bus_log2 bytes.
    function automatic logic [7:0] calc_strb(input logic [2:0] hsize,
                                             input logic [2:0] addr_lo,
                                             input logic [1:0] bus_log2);
        logic [3:0] bus_bytes;
        logic [8:0] full_mask;
        logic [7:0] base;
        logic [2:0] off;
        bus_bytes = 4'd1 << bus_log2;
        full_mask = (9'd1 << bus_bytes) - 9'd1;
        case (hsize)
            3'd0:    base = 8'h01;
            3'd1:    base = 8'h03;
            3'd2:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        off = addr_lo & ~((3'd1 << hsize) - 3'd1) & (bus_bytes[2:0] - 3'd1);
        if (hsize >= {1'b0, bus_log2}) begin
            return full_mask[7:0];
        end else begin
            return base << off;
        end
    endfunction

endpackage

// File: rtl/ahb2apb_bridge_param_decoder.sv
// Address-to-select decoder: one-hot APB select plus a flag for addresses beyond the last slave window.
module apb_slave_decoder
    import bridge_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int SLV_SPAN   = 12
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [NUM_SLAVES-1:0] sel_o,
    output logic                  unmapped_o
);

    localparam int IDX_W = ADDR_WIDTH - SLV_SPAN;

    logic [IDX_W-1:0]    idx_s;
    logic [SLV_SPAN-1:0] unused_offset_s;

    // Every bit above the window offset counts, so aliases past the last slave are unmapped.
    assign idx_s           = addr_i[ADDR_WIDTH-1:SLV_SPAN];
    assign unused_offset_s = addr_i[SLV_SPAN-1:0];

    // Decode the window index into a one-hot select.
    always_comb begin
        sel_o      = '0;
        unmapped_o = (idx_s >= IDX_W'(NUM_SLAVES));
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_s == IDX_W'(i)) begin
                sel_o[i] = 1'b1;
            end else begin
                sel_o[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ahb2apb_bridge_param.sv
// AHB slave to APB master bridge with wait states, strobes and a wait-state timeout.
// Define APB_SLVERR_EN to build the two-cycle AHB ERROR response path.
module ahb2apb_bridge_param
    import bridge_pkg::*;
#(
    parameter int NUM_SLAVES  = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int SLV_SPAN    = 12,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                    clock,
    input  logic                    Hresetn,
    input  logic [1:0]              Htrans,
    input  logic [2:0]              Hsize,
    input  logic [2:0]              Hburst,
    input  logic                    Hreadyin,
    input  logic [ADDR_WIDTH-1:0]   Haddr,
    input  logic                    Hwrite,
    input  logic [DATA_WIDTH-1:0]   Hwdata,
    output logic [DATA_WIDTH-1:0]   Hrdata,
    output logic [1:0]              Hresp,
    output logic                    Hreadyout,
    output logic [NUM_SLAVES-1:0]   Pselx,
    output logic                    Penable,
    output logic                    Pwrite,
    output logic [ADDR_WIDTH-1:0]   Paddr,
    output logic [DATA_WIDTH-1:0]   Pwdata,
    output logic [DATA_WIDTH/8-1:0] Pstrb,
    input  logic [DATA_WIDTH-1:0]   Prdata,
    input  logic                    Pready,
    input  logic                    Pslverr
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int BUS_LOG2 = $clog2(STRB_W);
    localparam int CNT_W    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    bridge_state_e           state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic                    pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [STRB_W-1:0]       pstrb_q, pstrb_d;
    logic [DATA_WIDTH-1:0]   hrdata_q, hrdata_d;
    logic [NUM_SLAVES-1:0]   pselx_q, pselx_d;
    logic                    penable_q, penable_d;
    logic                    hreadyout_q, hreadyout_d;
    hresp_e                  hresp_q, hresp_d;

    htrans_e                 htrans_s;
    logic                    accept_s;
    logic                    timeout_s;
    logic [ADDR_WIDTH-1:0]   dec_addr_s;
    logic [NUM_SLAVES-1:0]   dec_sel_s;
    logic                    dec_unmapped_s;
    logic [7:0]              strb_full_s;
    logic                    unused_s;

    assign htrans_s    = htrans_e'(Htrans);
    assign accept_s    = Hreadyin && (htrans_s == HTRANS_NONSEQ || htrans_s == HTRANS_SEQ)
                         && (state_q == ST_IDLE || state_q == ST_ERR2);
    // Decode the incoming address on acceptance, the latched one while the transfer runs.
    assign dec_addr_s  = accept_s ? Haddr : paddr_q;
    assign strb_full_s = calc_strb(Hsize, Haddr[2:0], 2'(BUS_LOG2));
    assign timeout_s   = (TIMEOUT_CYC != 0) && ((32'(cnt_q) + 32'd1) >= 32'(TIMEOUT_CYC));
    assign unused_s    = ^{Hburst, Pslverr, strb_full_s};

    apb_slave_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .SLV_SPAN   (SLV_SPAN)
    ) u_decoder (
        .addr_i     (dec_addr_s),
        .sel_o      (dec_sel_s),
        .unmapped_o (dec_unmapped_s)
    );

    // Next-state, APB shadow registers and registered-output values.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        pstrb_d  = pstrb_q;
        hrdata_d = hrdata_q;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (accept_s && dec_unmapped_s) begin
`ifdef APB_SLVERR_EN
                    state_d = ST_ERR1;
`else
                    state_d = ST_IDLE;
                    if (!Hwrite) begin
                        hrdata_d = '0;
                    end else begin
                        hrdata_d = hrdata_q;
                    end
`endif
                end else if (accept_s) begin
                    paddr_d  = Haddr;
                    pwrite_d = Hwrite;
                    pstrb_d  = Hwrite ? strb_full_s[STRB_W-1:0] : '0;
                    state_d  = Hwrite ? ST_WWAIT : ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WWAIT: begin
                pwdata_d = Hwdata;
                state_d  = ST_SETUP;
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (Pready) begin
`ifdef APB_SLVERR_EN
                    if (Pslverr) begin
                        state_d = ST_ERR1;
                    end else begin
                        state_d  = ST_IDLE;
                        hrdata_d = pwrite_q ? hrdata_q : Prdata;
                    end
`else
                    state_d  = ST_IDLE;
                    hrdata_d = pwrite_q ? hrdata_q : Prdata;
`endif
                end else if (timeout_s) begin
`ifdef APB_SLVERR_EN
                    state_d = ST_ERR1;
`else
                    state_d = ST_IDLE;
`endif
                    hrdata_d = '0;
                end else begin
                    state_d = ST_ACCESS;
                    cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
                end
            end
`ifdef APB_SLVERR_EN
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_SETUP) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_d;
        end

        hreadyout_d = (state_d == ST_IDLE) || (state_d == ST_ERR2);
        penable_d   = (state_d == ST_ACCESS);
        pselx_d     = (state_d == ST_SETUP || state_d == ST_ACCESS) ? dec_sel_s : '0;
`ifdef APB_SLVERR_EN
        hresp_d     = (state_d == ST_ERR1 || state_d == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
`else
        hresp_d     = HRESP_OKAY;
`endif
    end

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge clock or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            hrdata_q    <= '0;
            pselx_q     <= '0;
            penable_q   <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            hrdata_q    <= hrdata_d;
            pselx_q     <= pselx_d;
            penable_q   <= penable_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    assign Hrdata    = hrdata_q;
    assign Hresp     = hresp_q;
    assign Hreadyout = hreadyout_q;
    assign Pselx     = pselx_q;
    assign Penable   = penable_q;
    assign Pwrite    = pwrite_q;
    assign Paddr     = paddr_q;
    assign Pwdata    = pwdata_q;
    assign Pstrb     = pstrb_q;

endmodule

// File: tb/tb_ahb2apb_bridge_param.sv
// Directed plus randomized bench for ahb2apb_bridge_param with a transfer-level reference model.
module tb_ahb2apb_bridge_param;

    localparam int TO = 4;
`ifdef APB_SLVERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        Hresetn;
    logic [1:0]  Htrans;
    logic [2:0]  Hsize, Hburst;
    logic        Hreadyin, Hwrite;
    logic [31:0] Haddr, Hwdata, Hrdata, Paddr, Pwdata, Prdata;
    logic [1:0]  Hresp;
    logic        Hreadyout, Penable, Pwrite, Pready, Pslverr;
    logic [3:0]  Pselx, Pstrb;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_hrdata, exp_paddr, exp_pwdata;
    logic        exp_pwrite;
    logic [3:0]  exp_pstrb;

    ahb2apb_bridge_param #(
        .NUM_SLAVES(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .SLV_SPAN(12), .TIMEOUT_CYC(TO)
    ) dut (
        .clock(clock), .Hresetn(Hresetn), .Htrans(Htrans), .Hsize(Hsize), .Hburst(Hburst),
        .Hreadyin(Hreadyin), .Haddr(Haddr), .Hwrite(Hwrite), .Hwdata(Hwdata),
        .Hrdata(Hrdata), .Hresp(Hresp), .Hreadyout(Hreadyout), .Pselx(Pselx),
        .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata), .Pstrb(Pstrb),
        .Prdata(Prdata), .Pready(Pready), .Pslverr(Pslverr)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [3:0] model_strb(input logic [2:0] size, input logic [31:0] addr);
        int n;
        n = 1 << size;
        if (n >= 4) return 4'hF;
        return 4'(((1 << n) - 1) << ((int'(addr % 4) / n) * n));
    endfunction

    task automatic check_reset_outputs();
        chk("rst_hreadyout", 64'(Hreadyout), 64'd1);
        chk("rst_hresp", 64'(Hresp), 64'd0);
        chk("rst_hrdata", 64'(Hrdata), 64'd0);
        chk("rst_pselx", 64'(Pselx), 64'd0);
        chk("rst_penable", 64'(Penable), 64'd0);
        chk("rst_pwrite", 64'(Pwrite), 64'd0);
        chk("rst_paddr", 64'(Paddr), 64'd0);
        chk("rst_pwdata", 64'(Pwdata), 64'd0);
        chk("rst_pstrb", 64'(Pstrb), 64'd0);
    endtask

    // One AHB transfer whose address phase is the current cycle; returns in its final ready cycle.
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                        input logic [31:0] wdata, input logic [31:0] rdata, input int nwait,
                        input logic slverr, input bit idle_after);
        int idx, setup, alen, last_busy, c, fin, j;
        bit mapped, tmo, err;
        logic [3:0] exp_sel;
        logic       exp_en;
        idx    = int'(addr >> 12);
        mapped = (idx < 4);
        tmo    = mapped && (nwait >= TO);
        Htrans = 2'b10; Haddr = addr; Hwrite = wr; Hsize = size;
        Hburst = 3'($urandom); Hreadyin = 1'b1;
        Prdata = rdata; Pslverr = slverr; Pready = 1'($urandom);
        if (mapped) begin
            setup     = wr ? 2 : 1;
            alen      = tmo ? TO : nwait + 1;
            last_busy = setup + alen;
            err       = ERR_EN && (tmo || slverr);
            exp_paddr = addr; exp_pwrite = wr;
            exp_pstrb = wr ? model_strb(size, addr) : 4'h0;
            if (wr) exp_pwdata = wdata;
        end else begin
            setup = 99; alen = 0; last_busy = 0;
            err   = ERR_EN;
        end
        c   = last_busy + 1;
        fin = err ? c + 1 : c;
        if (tmo) exp_hrdata = 32'h0;
        else if (mapped && !wr && !err) exp_hrdata = rdata;
        else if (!mapped && !ERR_EN && !wr) exp_hrdata = 32'h0;
        for (int k = 1; k <= fin; k++) begin
            @(posedge clock); #1;
            Htrans   = (k == fin) ? 2'b00 : 2'($urandom);
            Haddr    = $urandom; Hwrite = 1'($urandom); Hsize = 3'($urandom_range(0, 2));
            Hreadyin = (k == fin) ? 1'b1 : 1'($urandom);
            Hwdata   = (k == 1) ? wdata : $urandom;
            j = k - setup - 1;
            if (mapped && j >= 0 && j < alen) Pready = tmo ? 1'b0 : (j >= nwait);
            else Pready = 1'($urandom);
            exp_sel = (mapped && k >= setup && k <= last_busy) ? 4'(1 << idx) : 4'h0;
            exp_en  = mapped && k > setup && k <= last_busy;
            chk("hreadyout", 64'(Hreadyout), 64'(k == fin));
            chk("hresp", 64'(Hresp), 64'((err && k >= c) ? 2'b01 : 2'b00));
            chk("pselx", 64'(Pselx), 64'(exp_sel));
            chk("penable", 64'(Penable), 64'(exp_en));
            if (exp_sel != 4'h0) begin
                chk("paddr", 64'(Paddr), 64'(exp_paddr));
                chk("pwrite", 64'(Pwrite), 64'(exp_pwrite));
                chk("pstrb", 64'(Pstrb), 64'(exp_pstrb));
                chk("pwdata", 64'(Pwdata), 64'(exp_pwdata));
            end
        end
        chk("hrdata", 64'(Hrdata), 64'(exp_hrdata));
        chk("paddr_hold", 64'(Paddr), 64'(exp_paddr));
        if (idle_after) begin
            @(posedge clock); #1;
            chk("idle_ready", 64'(Hreadyout), 64'd1);
            chk("idle_resp", 64'(Hresp), 64'd0);
        end
    endtask

    initial begin
        Hresetn = 1'b0; Htrans = 2'b00; Hsize = 3'd0; Hburst = 3'd0; Hreadyin = 1'b1;
        Haddr = 32'h0; Hwrite = 1'b0; Hwdata = 32'h0; Prdata = 32'h0; Pready = 1'b1; Pslverr = 1'b0;
        exp_hrdata = 32'h0; exp_paddr = 32'h0; exp_pwdata = 32'h0; exp_pwrite = 1'b0; exp_pstrb = 4'h0;
        @(posedge clock); @(posedge clock); #1;
        check_reset_outputs();
        Hresetn = 1'b1;
        @(posedge clock); #1;

        // Directed: zero-wait read, byte write, Pready low 3 cycles, back-to-back reads.
        xfer(32'h0000_1004, 1'b0, 3'd2, 32'h0, 32'hCAFE_F00D, 0, 1'b0, 1'b1);
        xfer(32'h0000_0003, 1'b1, 3'd0, 32'hAB00_0000, 32'h0, 0, 1'b0, 1'b1);
        xfer(32'h0000_2010, 1'b0, 3'd2, 32'h0, 32'h1234_5678, 3, 1'b0, 1'b0);
        xfer(32'h0000_3020, 1'b0, 3'd2, 32'h0, 32'h8765_4321, 0, 1'b0, 1'b0);
        xfer(32'h0000_0040, 1'b0, 3'd2, 32'h0, 32'h5A5A_A5A5, 0, 1'b0, 1'b1);
        // Slave error, unmapped address, stuck-low timeout.
        xfer(32'h0000_1100, 1'b0, 3'd2, 32'h0, 32'hDEAD_BEEF, 0, 1'b1, 1'b1);
        xfer(32'h0000_4000, 1'b0, 3'd2, 32'h0, 32'h1111_1111, 0, 1'b0, 1'b1);
        xfer(32'h0000_4000, 1'b1, 3'd2, 32'h7777_7777, 32'h0, 0, 1'b0, 1'b1);
        xfer(32'h0000_2200, 1'b0, 3'd2, 32'h0, 32'h2222_2222, 10, 1'b0, 1'b1);

        // Reset asserted in the middle of ACCESS.
        Htrans = 2'b10; Haddr = 32'h0000_2000; Hwrite = 1'b0; Hsize = 3'd2; Pready = 1'b0;
        @(posedge clock); #1; Htrans = 2'b00;
        @(posedge clock); #1;
        chk("mid_penable", 64'(Penable), 64'd1);
        @(posedge clock); #2;
        Hresetn = 1'b0; #1;
        check_reset_outputs();
        exp_hrdata = 32'h0; exp_paddr = 32'h0; exp_pwdata = 32'h0; exp_pwrite = 1'b0; exp_pstrb = 4'h0;
        @(posedge clock); #1; Hresetn = 1'b1; Pready = 1'b1;
        @(posedge clock); #1;
        chk("post_rst_ready", 64'(Hreadyout), 64'd1);

        // Randomized transfers, mostly mapped, with back-to-back and idle gaps mixed.
        for (int n = 0; n < 60; n++) begin
            xfer({16'h0, 4'($urandom_range(0, 4)), 12'($urandom)}, 1'($urandom),
                 3'($urandom_range(0, 2)), $urandom, $urandom, $urandom_range(0, 5),
                 1'($urandom_range(0, 3) == 0), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
